// File: rtl/vdac_pkg.sv
// Shared widths, fade limits and fade FSM state type for the vdac sequencer.
package vdac_pkg;
  localparam int FADE_MAX = 16;
  localparam int LVL_W    = 5;
  localparam int COL_W    = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fade_state_t;
endpackage

// File: rtl/vdac_scale.sv
// Combinational colour x brightness scaler: (color * level) >> 4, saturating at full scale.
module vdac_scale
  import vdac_pkg::*;
(
  input  logic [COL_W-1:0] color,
  input  logic [LVL_W-1:0] level,
  output logic [COL_W-1:0] scaled
);
  logic [COL_W+LVL_W-1:0] prod;

  assign prod = color * level;
  // Level 16 is unity gain; anything reaching bit 9 would overflow the 5-bit output.
  assign scaled = prod[COL_W+LVL_W-1] ? {COL_W{1'b1}} : prod[COL_W+3:4];
endmodule

// File: rtl/vdac_seq.sv
// Pixel/sync pipeline with blanking, frame-stepped brightness fade and
// vblank-aligned mode switching in front of the vdac mapper.
module vdac_seq
  import vdac_pkg::*;
#(
  parameter int FADE_MAX = vdac_pkg::FADE_MAX,
  parameter int SPD_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             hblank,
  input  logic             vblank,
  input  logic             hsync,
  input  logic             vsync,
  input  logic [4:0]       i_r,
  input  logic [4:0]       i_g,
  input  logic [4:0]       i_b,
  input  logic             mode_req,
  input  logic             mode_stb,
  input  logic             fade_start,
  input  logic             fade_dir,
  input  logic [SPD_W-1:0] fade_speed,
  output logic [4:0]       o_r,
  output logic [4:0]       o_g,
  output logic [4:0]       o_b,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_blank,
  output logic             mode,
  output logic             fade_busy,
  output logic [4:0]       fade_level
);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(FADE_MAX);

  logic             hsync_reg, vsync_reg, blank_reg, vblank_prev_reg;
  logic             mode_reg, mode_pend_reg, mode_req_reg;
  fade_state_t      state_reg, state_next;
  logic [LVL_W-1:0] level_reg, level_next;
  logic [SPD_W-1:0] cnt_reg, cnt_next, spd_reg, spd_next;
  logic             dir_reg, dir_next, busy_reg, busy_next;
  logic             frame_tick, vblank_rise, blank_in;
  logic [LVL_W-1:0] target_in, target_run;
  logic [COL_W-1:0] col_in [3];

  assign blank_in    = hblank | vblank;
  assign frame_tick  = ce & vsync & ~vsync_reg;
  assign vblank_rise = ce & vblank & ~vblank_prev_reg;
  assign col_in[0]   = i_r;
  assign col_in[1]   = i_g;
  assign col_in[2]   = i_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_reg       <= 1'b0;
      vsync_reg       <= 1'b0;
      blank_reg       <= 1'b1;
      vblank_prev_reg <= 1'b0;
    end else if (ce) begin
      hsync_reg       <= hsync;
      vsync_reg       <= vsync;
      blank_reg       <= blank_in;
      vblank_prev_reg <= vblank;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      logic [COL_W-1:0] scaled;
      logic [COL_W-1:0] px_reg;

      vdac_scale u_scale (
        .color  (col_in[gi]),
        .level  (level_reg),
        .scaled (scaled)
      );

      always_ff @(posedge clk) begin
        if (rst)     px_reg <= '0;
        else if (ce) px_reg <= blank_in ? '0 : scaled;
      end
    end
  endgenerate

  // The strobe is not ce-qualified; a strobe landing on the edge itself wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg      <= 1'b0;
      mode_pend_reg <= 1'b0;
      mode_req_reg  <= 1'b0;
    end else if (vblank_rise && mode_stb) begin
      mode_reg      <= mode_req;
      mode_req_reg  <= mode_req;
      mode_pend_reg <= 1'b0;
    end else if (vblank_rise && mode_pend_reg) begin
      mode_reg      <= mode_req_reg;
      mode_pend_reg <= 1'b0;
    end else if (mode_stb) begin
      mode_req_reg  <= mode_req;
      mode_pend_reg <= 1'b1;
    end
  end

  assign target_in  = fade_dir ? LVL_MAX : '0;
  assign target_run = dir_reg  ? LVL_MAX : '0;

  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    cnt_next   = cnt_reg;
    dir_next   = dir_reg;
    spd_next   = spd_reg;
    if (ce) begin
      if (fade_start) begin
        dir_next   = fade_dir;
        spd_next   = fade_speed;
        cnt_next   = '0;
        state_next = (level_reg != target_in) ? RUN : IDLE;
      end else if (state_reg == RUN && frame_tick) begin
        if (cnt_reg == spd_reg) begin
          cnt_next   = '0;
          level_next = dir_reg ? level_reg + 1'b1 : level_reg - 1'b1;
          if (level_next == target_run) state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
    end
    busy_next = (state_next == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      level_reg <= LVL_MAX;
      cnt_reg   <= '0;
      dir_reg   <= 1'b0;
      spd_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      level_reg <= level_next;
      cnt_reg   <= cnt_next;
      dir_reg   <= dir_next;
      spd_reg   <= spd_next;
      busy_reg  <= busy_next;
    end
  end

  assign o_r        = g_ch[0].px_reg;
  assign o_g        = g_ch[1].px_reg;
  assign o_b        = g_ch[2].px_reg;
  assign o_hsync    = hsync_reg;
  assign o_vsync    = vsync_reg;
  assign o_blank    = blank_reg;
  assign mode       = mode_reg;
  assign fade_busy  = busy_reg;
  assign fade_level = level_reg;
endmodule

// File: tb/tb_vdac_seq.sv
// Directed self-checking bench for vdac_seq: pixel path, sync delay, mode timing, fades, reset.
module tb_vdac_seq;
  logic       clk = 1'b0;
  logic       rst, ce, hblank, vblank, hsync, vsync;
  logic [4:0] i_r, i_g, i_b;
  logic       mode_req, mode_stb, fade_start, fade_dir;
  logic [3:0] fade_speed;
  logic [4:0] o_r, o_g, o_b, fade_level;
  logic       o_hsync, o_vsync, o_blank, mode, fade_busy;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  vdac_seq #(.FADE_MAX(16), .SPD_W(4)) dut (
    .clk(clk), .rst(rst), .ce(ce), .hblank(hblank), .vblank(vblank),
    .hsync(hsync), .vsync(vsync), .i_r(i_r), .i_g(i_g), .i_b(i_b),
    .mode_req(mode_req), .mode_stb(mode_stb), .fade_start(fade_start),
    .fade_dir(fade_dir), .fade_speed(fade_speed),
    .o_r(o_r), .o_g(o_g), .o_b(o_b), .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_blank(o_blank), .mode(mode), .fade_busy(fade_busy), .fade_level(fade_level)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      vsync = 1'b1; step();
      vsync = 1'b0; step();
    end
  endtask

  task automatic start(input logic dir, input logic [3:0] spd);
    fade_start = 1'b1; fade_dir = dir; fade_speed = spd;
    step();
    fade_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; hblank = 1'b0; vblank = 1'b0; hsync = 1'b0; vsync = 1'b0;
    i_r = 5'd31; i_g = 5'd16; i_b = 5'd1;
    mode_req = 1'b0; mode_stb = 1'b0; fade_start = 1'b0; fade_dir = 1'b0; fade_speed = 4'd0;
    step(); step();
    chk("rst_o_r", o_r, 0);
    chk("rst_o_blank", o_blank, 1);
    chk("rst_mode", mode, 0);
    chk("rst_level", fade_level, 16);
    chk("rst_busy", fade_busy, 0);
    $display("reset: o_r=%0d o_blank=%0d level=%0d", o_r, o_blank, fade_level);

    rst = 1'b0; step();
    chk("pix_r", o_r, 31); chk("pix_g", o_g, 16); chk("pix_b", o_b, 1);
    chk("pix_blank", o_blank, 0);
    $display("pixel: r=%0d g=%0d b=%0d", o_r, o_g, o_b);

    hblank = 1'b1; hsync = 1'b1; step();
    chk("hblank_r", o_r, 0); chk("hblank_blank", o_blank, 1); chk("hsync_dly", o_hsync, 1);
    hblank = 1'b0; hsync = 1'b0; step();
    chk("unblank_r", o_r, 31); chk("hsync_low", o_hsync, 0);
    $display("blank/sync: r=%0d blank=%0d hsync=%0d", o_r, o_blank, o_hsync);

    ce = 1'b0; hblank = 1'b1; hsync = 1'b1; vsync = 1'b1; i_r = 5'd0; step(); step();
    chk("freeze_r", o_r, 31); chk("freeze_blank", o_blank, 0);
    chk("freeze_hsync", o_hsync, 0); chk("freeze_vsync", o_vsync, 0);
    ce = 1'b1; hblank = 1'b0; hsync = 1'b0; vsync = 1'b0; i_r = 5'd31; step();
    $display("ce freeze: r=%0d hsync=%0d", o_r, o_hsync);

    // Overwritten strobe: 1 then 0 before the edge leaves mode at 0.
    mode_stb = 1'b1; mode_req = 1'b1; step();
    mode_req = 1'b0; step();
    mode_stb = 1'b0; vblank = 1'b1; step();
    chk("mode_overwrite", mode, 0);
    vblank = 1'b0; step();
    mode_stb = 1'b1; mode_req = 1'b1; step();
    mode_stb = 1'b0; step(); step();
    chk("mode_hold_midline", mode, 0);
    vblank = 1'b1; step();
    chk("mode_at_edge", mode, 1);
    vblank = 1'b0; step();
    vblank = 1'b1; mode_stb = 1'b1; mode_req = 1'b0; step();
    mode_stb = 1'b0;
    chk("mode_stb_on_edge", mode, 0);
    vblank = 1'b0; step();
    $display("mode sequence done: mode=%0d", mode);

    start(1'b0, 4'd1);
    chk("fo_busy", fade_busy, 1); chk("fo_level0", fade_level, 16);
    ticks(16);
    chk("fo_level8", fade_level, 8);
    step();
    chk("fo_r_at8", o_r, 15);
    ticks(15);
    chk("fo_level1", fade_level, 1); chk("fo_busy1", fade_busy, 1);
    vsync = 1'b1; step();
    chk("fo_level_end", fade_level, 0); chk("fo_busy_end", fade_busy, 0);
    vsync = 1'b0; step();
    chk("fo_r_at0", o_r, 0);
    $display("fade out: level=%0d busy=%0d", fade_level, fade_busy);

    start(1'b1, 4'd0);
    ticks(5);
    chk("fi_level5", fade_level, 5);
    start(1'b1, 4'd0);
    ticks(10);
    chk("fi_level15", fade_level, 15); chk("fi_busy15", fade_busy, 1);
    ticks(1);
    chk("fi_level16", fade_level, 16); chk("fi_busy16", fade_busy, 0);
    start(1'b1, 4'd0);
    chk("fi_at_target_busy", fade_busy, 0);
    $display("fade in: level=%0d busy=%0d", fade_level, fade_busy);

    start(1'b0, 4'd0);
    ticks(8);
    start(1'b1, 4'd0);
    ticks(2);
    chk("rs_level10", fade_level, 10);
    vsync = 1'b1; start(1'b0, 4'd0);
    chk("rs_start_wins", fade_level, 10); chk("rs_busy", fade_busy, 1);
    vsync = 1'b0; step();
    ticks(1);
    chk("rs_level9", fade_level, 9);
    ticks(2);
    chk("rs_level7", fade_level, 7);
    $display("restart: level=%0d busy=%0d", fade_level, fade_busy);

    mode_stb = 1'b1; mode_req = 1'b1; step();
    mode_stb = 1'b0; vblank = 1'b1; step();
    chk("pre_rst_mode", mode, 1);
    vblank = 1'b0; step();
    rst = 1'b1; step();
    chk("midrst_level", fade_level, 16); chk("midrst_busy", fade_busy, 0);
    chk("midrst_mode", mode, 0); chk("midrst_blank", o_blank, 1);
    rst = 1'b0;
    $display("mid-fade reset: level=%0d busy=%0d mode=%0d", fade_level, fade_busy, mode);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
